// File: rtl/moving_sum_decoder.sv
// moving_sum_decoder: recovers x[n] from a wrap-around DEPTH-sample moving-sum
// stream y[n] = x[n] + ... + x[n-DEPTH+1] (mod 2^WIDTH).
// Recovery: x[n] = y[n] - y[n-1] + x[n-DEPTH], all in wrap arithmetic.
// Optional synchronous stream restart port clr is enabled by defining
// MOVING_SUM_DECODER_CLR_EN.
module moving_sum_decoder #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                    system1000,
   input  logic                    system1000_rstn,
`ifdef MOVING_SUM_DECODER_CLR_EN
   input  logic                    clr,
`endif
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] in_sample,
   output logic                    out_valid,
   output logic signed [WIDTH-1:0] out_sample
);

   localparam int HIST_W = DEPTH * WIDTH;

   // hist_reg[WIDTH-1:0] is the newest recovered sample, the top slice the oldest
   logic [HIST_W-1:0]       hist_reg;
   logic [HIST_W-1:0]       hist_next;
   logic signed [WIDTH-1:0] prev_y_reg;
   logic signed [WIDTH-1:0] oldest;
   logic signed [WIDTH-1:0] x_next;
   logic                    clear;

`ifdef MOVING_SUM_DECODER_CLR_EN
   assign clear = clr;
`else
   assign clear = 1'b0;
`endif

   // decode the incoming sample and form the shifted history
   always_comb begin
      oldest    = hist_reg[HIST_W-1 -: WIDTH];
      x_next    = in_sample - prev_y_reg + oldest;
      hist_next = {hist_reg[HIST_W-WIDTH-1:0], x_next};
   end

   // state update: async reset, clr restarts the stream, otherwise advance on in_valid
   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         hist_reg   <= '0;
         prev_y_reg <= '0;
         out_sample <= '0;
         out_valid  <= 1'b0;
      end else if (clear) begin
         hist_reg   <= '0;
         prev_y_reg <= '0;
         out_sample <= '0;
         out_valid  <= 1'b0;
      end else if (in_valid) begin
         hist_reg   <= hist_next;
         prev_y_reg <= in_sample;
         out_sample <= x_next;
         out_valid  <= 1'b1;
      end else begin
         out_valid  <= 1'b0;
      end
   end

endmodule
